pipe_shifter: RTL

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/pipe_shifter.sv | 80 ++++++++
 1 files changed

// File: rtl/pipe_shifter.sv
// pipe_shifter: 2-stage valid/ready barrel shifter (SLL/SRL/SRA/ROR); define PIPE_SHIFTER_ROTATE_EN for rotate, otherwise opcode 11 acts as SRL
module pipe_shifter #(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [SW-1:0]    shamt,
  input  logic [1:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_op;
  logic [1:0]       s1_fine;
  logic [SW-1:0]    c_amt;
  logic [WIDTH-1:0] c_sra;
  logic [WIDTH-1:0] c_data;
  logic [WIDTH-1:0] f_sra;
  logic [WIDTH-1:0] f_data;
  logic             s2_en;
`ifdef PIPE_SHIFTER_ROTATE_EN
  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x, input logic [SW-2:0] r);
    logic [2*WIDTH-1:0] t;
    t = {x, x} >> r;
    return t[WIDTH-1:0];
  endfunction
`endif
  assign s2_en    = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_en;
  assign c_amt    = {shamt[SW-1:2], 2'b00};
  assign c_sra    = $signed(operand) >>> c_amt;
  assign f_sra    = $signed(s1_data) >>> s1_fine;
  // coarse shift by a multiple of four; rotate amounts wrap modulo WIDTH
  always_comb begin
    c_data = opcode == 2'b00 ? operand << c_amt : opcode == 2'b10 ? c_sra : operand >> c_amt;
`ifdef PIPE_SHIFTER_ROTATE_EN
    c_data = opcode == 2'b11 ? rot(operand, c_amt[SW-2:0]) : c_data;
`endif
  end
  // fine shift by the low two bits of the amount
  always_comb begin
    f_data = s1_op == 2'b00 ? s1_data << s1_fine : s1_op == 2'b10 ? f_sra : s1_data >> s1_fine;
`ifdef PIPE_SHIFTER_ROTATE_EN
    f_data = s1_op == 2'b11 ? rot(s1_data, (SW-1)'(s1_fine)) : f_data;
`endif
  end
  // stage 1 loads whenever it is empty or stage 2 can take its contents
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= '0;
      s1_fine  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      s1_data  <= c_data;
      s1_op    <= opcode;
      s1_fine  <= shamt[1:0];
    end
  // stage 2 holds the visible result while the consumer stalls
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= f_data;
        zero   <= f_data == '0;
      end
    end
endmodule
